// File: rtl/wb_timeout_bridge_pkg.sv
// wb_timeout_bridge_pkg: shared WISHBONE stage types (bridge state, termination bundle)
package wb_timeout_bridge_pkg;
  typedef enum logic {PASS, ERR} bridge_state_e;
  typedef struct packed {
    logic ack;
    logic err;
    logic rty;
  } wb_term_t;
  function automatic logic term_any(input wb_term_t t);
    return t.ack | t.err | t.rty;
  endfunction
endpackage

// File: rtl/wb_sat_counter.sv
// wb_sat_counter: saturating event counter with synchronous clear; clear and increment together yield 1
module wb_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= clr ? CNT_WIDTH'(inc) : (inc && !(&cnt)) ? cnt + CNT_WIDTH'(1) : cnt;
endmodule

// File: rtl/wb_timeout_bridge.sv
// wb_timeout_bridge: zero-latency WB classic pass-through that aborts and errs transfers left unterminated too long
module wb_timeout_bridge
  import wb_timeout_bridge_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    s_cyc_i,
  input  logic                    s_stb_i,
  input  logic                    s_we_i,
  input  logic [ADDRESS_WIDTH-1:0] s_adr_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic [DATA_WIDTH/8-1:0] s_sel_i,
  output logic                    s_ack_o,
  output logic                    s_err_o,
  output logic                    s_rty_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    m_cyc_o,
  output logic                    m_stb_o,
  output logic                    m_we_o,
  output logic [ADDRESS_WIDTH-1:0] m_adr_o,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  output logic [DATA_WIDTH/8-1:0] m_sel_o,
  input  logic                    m_ack_i,
  input  logic                    m_err_i,
  input  logic                    m_rty_i,
  input  logic [DATA_WIDTH-1:0]   m_dat_i,
  output logic                    timeout_o,
  output logic [CNT_WIDTH-1:0]    timeout_cnt_o,
  input  logic                    cnt_clr_i
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  bridge_state_e state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  wb_term_t m_term;
  logic strobe, term, expire, abort;
  assign m_term = '{ack: m_ack_i, err: m_err_i, rty: m_rty_i};
  assign strobe = s_cyc_i & s_stb_i;
  assign term   = term_any(m_term);
  // a termination on the final waiting cycle wins over the timeout
  assign expire = strobe && !term && timer == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= PASS;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
    end
  always_comb begin
    state_nx = (state == PASS && expire) ? ERR : PASS;
    timer_nx = (state == PASS && strobe && !term && !expire) ? timer + TW'(1) : '0;
  end
  always_comb begin
    abort     = state == ERR;
    m_cyc_o   = s_cyc_i & ~abort;
    m_stb_o   = strobe & ~abort;
    s_ack_o   = strobe & ~abort & m_term.ack;
    s_err_o   = strobe & (abort | m_term.err);
    s_rty_o   = strobe & ~abort & m_term.rty;
    timeout_o = abort;
  end
  assign m_we_o  = s_we_i;
  assign m_adr_o = s_adr_i;
  assign m_dat_o = s_dat_i;
  assign m_sel_o = s_sel_i;
  assign s_dat_o = m_dat_i;
  wb_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk(clk_i),
    .rst(rst_i),
    .inc(timeout_o),
    .clr(cnt_clr_i),
    .cnt(timeout_cnt_o)
  );
endmodule

// File: doc/wb_timeout_bridge.md
Name: wb_timeout_bridge

Overview:
- WISHBONE classic-cycle pass-through stage between one host (master) and the device/interconnect port it drives.
- Forwards every request combinationally, with zero added latency, and watches for a termination.
- If no ack/err/rty arrives within TIMEOUT_CYCLES, aborts the device-side cycle and terminates the host transfer with err.
- Keeps a hung or absent slave from locking up the master; counts timeouts for status.

Parameters:
- ADDRESS_WIDTH, 16, WB address width.
- DATA_WIDTH, 32, WB data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 256, cycles a strobed transfer waits before abort; must be >= 2.
- CNT_WIDTH, 16, width of the saturating timeout counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- s_cyc_i, s_stb_i, s_we_i  in  1 each  host request.
- s_adr_i  in  ADDRESS_WIDTH  host address.
- s_dat_i  in  DATA_WIDTH  host write data.
- s_sel_i  in  DATA_WIDTH/8  host byte selects.
- s_ack_o, s_err_o, s_rty_o  out  1 each  terminations to host.
- s_dat_o  out  DATA_WIDTH  read data to host.
- m_cyc_o, m_stb_o, m_we_o  out  1 each  request to device.
- m_adr_o  out  ADDRESS_WIDTH  device address.
- m_dat_o  out  DATA_WIDTH  device write data.
- m_sel_o  out  DATA_WIDTH/8  device byte selects.
- m_ack_i, m_err_i, m_rty_i  in  1 each  device terminations.
- m_dat_i  in  DATA_WIDTH  device read data.
- timeout_o  out  1  one-cycle pulse per timeout event.
- timeout_cnt_o  out  CNT_WIDTH  saturating timeout count.
- cnt_clr_i  in  1  synchronous clear of timeout_cnt_o.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=PASS, timer=0, timeout_o=0, timeout_cnt_o=0.
  - Combinational outputs follow PASS rules; m_cyc_o/m_stb_o are 0 while s_cyc_i/s_stb_i are 0.
  - Reset mid-transfer drops any pending timeout; no err is issued.
- Timer: width $clog2(TIMEOUT_CYCLES+1).
- State PASS:
  - m_cyc_o=s_cyc_i; m_stb_o=s_cyc_i&s_stb_i.
  - m_we_o/m_adr_o/m_dat_o/m_sel_o = host values, unmodified.
  - s_dat_o=m_dat_i.
  - s_ack_o=m_ack_i&s_cyc_i&s_stb_i; s_err_o and s_rty_o are gated the same way.
  - Timer increments each cycle with s_cyc_i&s_stb_i=1 and no m_ack_i/m_err_i/m_rty_i.
  - Timer clears to 0 on any termination, or whenever s_cyc_i=0 or s_stb_i=0.
  - Timeout condition: timer==TIMEOUT_CYCLES-1, strobe still high, no termination this cycle. Result:
    - next state=ERR, timeout_o=1 next cycle.
    - First strobed cycle counts as 1, so host err occurs on strobed cycle TIMEOUT_CYCLES+1.
- State ERR (exactly one cycle):
  - m_cyc_o=0, m_stb_o=0 (abort to device).
  - s_err_o=1 if s_cyc_i&s_stb_i, else 0; s_ack_o=s_rty_o=0.
  - m_ack_i/m_err_i/m_rty_i are ignored.
  - timer=0; next state=PASS unconditionally.
  - A host strobe on the following cycle is treated as a new transfer.
- Simultaneous events:
  - Termination on the timeout-condition cycle: the termination wins, no timeout, timer clears.
  - Host drops s_cyc_i mid-wait: timer clears, no err.
  - cnt_clr_i and timeout increment in the same cycle: counter becomes 1.
- timeout_cnt_o:
  - +1 on each cycle where timeout_o=1.
  - Saturates at 2^CNT_WIDTH-1 (no wrap).
  - cnt_clr_i sets it to 0.
- Multiple terminations asserted together from the device are passed through as-is; no priority encoding.

Decomposition:
- Shared package gets a state enum (PASS, ERR) and a WB termination bundle typedef (ack/err/rty) for reuse by other WB stages.
- One natural sub-module: wb_sat_counter (CNT_WIDTH, inc, clr, saturate), reusable for other bus status counters.
- Ports use the codebase's named WB interface port macros with prefixes s and m.

Test Plan (TIMEOUT_CYCLES=8, CNT_WIDTH=4):
- Normal read: strobe, m_ack_i on 3rd strobed cycle with m_dat_i=0xDEADBEEF -> s_ack_o same cycle, s_dat_o=0xDEADBEEF, timeout_o never 1, count 0.
- Hung slave: strobe held, no termination -> timer reaches 7 on strobed cycle 8; cycle 9 shows m_cyc_o=0, s_err_o=1, timeout_o=1; count=1; cycle 10 back to PASS.
- Race: m_ack_i on strobed cycle 8 (the timeout-condition cycle) -> s_ack_o=1, no err, timeout_o=0, count unchanged.
- Abort by host: s_cyc_i dropped after 5 strobed cycles, then a new strobe acked on cycle 6 -> no err; timer restarts from 0.
- Saturation/clear: force 16 timeouts -> count holds at 15; cnt_clr_i coincident with a timeout -> count=1.
- Reset mid-wait: rst_i pulsed at strobed cycle 6 -> next cycle timer=0, timeout_o=0, count=0; no err issued.
